// File: rtl/bus_ram_dp.sv
// Shared RAM: 32-bit bus port plus a wide user port on one clock, with a small
// CTRL/COLL register window, collision counting and a level IRQ.
module bus_ram_dp #(
    parameter int unsigned BUS_ADDR   = 0,
    parameter int unsigned LOGSIZE    = 16,
    parameter int unsigned REG_ADDR   = BUS_ADDR + (1 << LOGSIZE),
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned USR_WIDTH  = 64
) (
    input  logic                                    bus_clk_i,
    input  logic                                    bus_reset_l_i,
    input  logic [31:0]                             bus_addr_i,
    input  logic                                    bus_rd_i,
    input  logic                                    bus_wr_i,
    input  logic [3:0]                              bus_be_i,
    input  logic [31:0]                             bus_wr_data_i,
    output logic [31:0]                             bus_rd_data_o,
    output logic                                    bus_rd_ack_o,
    output logic                                    bus_wr_ack_o,
    output logic                                    bus_irq_o,
    input  logic [LOGSIZE-$clog2(USR_WIDTH/8)-1:0]  usr_addr_i,
    input  logic                                    usr_rd_en_i,
    input  logic                                    usr_we_i,
    input  logic [USR_WIDTH/8-1:0]                  usr_be_i,
    input  logic [USR_WIDTH-1:0]                    usr_wr_data_i,
    output logic [USR_WIDTH-1:0]                    usr_rd_data_o,
    output logic                                    usr_rd_valid_o
);

    localparam int unsigned SIZE   = 1 << LOGSIZE;
    localparam int unsigned UB     = USR_WIDTH / 8;
    localparam int unsigned UB_LG  = $clog2(UB);
    localparam int unsigned NB     = USR_WIDTH / 32;
    localparam int unsigned UAW    = LOGSIZE - UB_LG;
    localparam int unsigned DEPTH  = 1 << UAW;
    localparam int unsigned LANE_W = (NB > 1) ? $clog2(NB) : 1;

    logic [USR_WIDTH-1:0] mem [DEPTH];

    logic [31:0]        bus_off;
    logic [UAW-1:0]     bus_uaddr;
    logic [LANE_W-1:0]  bus_lane;
    logic               ram_hit, ctrl_hit, coll_hit, bus_rd_hit;
    logic [3:0]         bus_be_eff;
    logic [UB-1:0]      usr_be_eff;
    logic               usr_lane_w, collision, coll_wr;
    logic [31:0]        bus_rd_word;

    logic [2:0]  ctrl_q, ctrl_d;
    logic [15:0] coll_q, coll_d;
    logic        irq_q, irq_d;
    logic        wr_ack_q;

    logic                 bus_v_q [RD_LATENCY];
    logic [31:0]          bus_d_q [RD_LATENCY];
    logic                 usr_v_q [RD_LATENCY];
    logic [USR_WIDTH-1:0] usr_d_q [RD_LATENCY];

    assign bus_off   = bus_addr_i - 32'(BUS_ADDR);
    assign ram_hit   = bus_off < 32'(SIZE);
    assign ctrl_hit  = bus_addr_i == 32'(REG_ADDR);
    assign coll_hit  = bus_addr_i == 32'(REG_ADDR) + 32'd4;
    assign bus_uaddr = bus_off[LOGSIZE-1 -: UAW];

    generate
        if (NB > 1) begin : g_lane
            assign bus_lane = bus_off[UB_LG-1:2];
        end else begin : g_nolane
            assign bus_lane = '0;
        end
    endgenerate

    // Write gating: wp blocks the bus, usr_wr_en gates the user port.
    assign bus_be_eff = (bus_wr_i && ram_hit && !ctrl_q[0]) ? bus_be_i : 4'b0000;
    assign usr_be_eff = (usr_we_i && ctrl_q[1]) ? usr_be_i : '0;
    assign bus_rd_hit = bus_rd_i && (ram_hit || ctrl_hit || coll_hit);

    // Collision: same 32-bit word this cycle with at least one effective write.
    assign usr_lane_w = |usr_be_eff[{bus_lane, 2'b00} +: 4];
    assign collision  = ram_hit && (bus_rd_i || bus_wr_i) && (bus_uaddr == usr_addr_i)
                        && (usr_lane_w || (bus_wr_i && !ctrl_q[0] && usr_rd_en_i));
    assign coll_wr    = bus_wr_i && coll_hit;

    always_comb begin
        bus_rd_word = mem[bus_uaddr][{bus_lane, 5'b00000} +: 32];
        if (ctrl_hit) begin
            bus_rd_word = {29'b0, ctrl_q};
        end else if (coll_hit) begin
            bus_rd_word = {16'b0, coll_q};
        end
    end

    always_comb begin
        ctrl_d = ctrl_q;
        coll_d = coll_q;
        if (bus_wr_i && ctrl_hit && bus_be_i[0]) begin
            ctrl_d = bus_wr_data_i[2:0];
        end
        if (coll_wr) begin
            coll_d = 16'd0;
        end
        if (collision) begin
            coll_d = coll_wr ? 16'd1 : ((coll_q == 16'hFFFF) ? coll_q : coll_q + 16'd1);
        end
        irq_d = ctrl_d[2] && (coll_d != 16'd0);
    end

    // User bytes land first so overlapping bus bytes overwrite them.
    always_ff @(posedge bus_clk_i) begin
        for (int k = 0; k < int'(UB); k++) begin
            if (usr_be_eff[k]) mem[usr_addr_i][k*8 +: 8] <= usr_wr_data_i[k*8 +: 8];
        end
        for (int k = 0; k < 4; k++) begin
            if (bus_be_eff[k]) mem[bus_uaddr][{bus_lane, 5'b00000} + 8*k +: 8] <= bus_wr_data_i[k*8 +: 8];
        end
    end

    always_ff @(posedge bus_clk_i or negedge bus_reset_l_i) begin
        if (!bus_reset_l_i) begin
            ctrl_q   <= 3'b010;
            coll_q   <= 16'd0;
            irq_q    <= 1'b0;
            wr_ack_q <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            coll_q   <= coll_d;
            irq_q    <= irq_d;
            wr_ack_q <= bus_wr_i && (ram_hit || ctrl_hit || coll_hit);
        end
    end

    // Read pipelines; data stages load only on valid so the last word is held.
    always_ff @(posedge bus_clk_i or negedge bus_reset_l_i) begin
        if (!bus_reset_l_i) begin
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                bus_v_q[i] <= 1'b0;
                bus_d_q[i] <= '0;
                usr_v_q[i] <= 1'b0;
                usr_d_q[i] <= '0;
            end
        end else begin
            bus_v_q[0] <= bus_rd_hit;
            if (bus_rd_hit) bus_d_q[0] <= bus_rd_word;
            usr_v_q[0] <= usr_rd_en_i;
            if (usr_rd_en_i) usr_d_q[0] <= mem[usr_addr_i];
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                bus_v_q[i] <= bus_v_q[i-1];
                if (bus_v_q[i-1]) bus_d_q[i] <= bus_d_q[i-1];
                usr_v_q[i] <= usr_v_q[i-1];
                if (usr_v_q[i-1]) usr_d_q[i] <= usr_d_q[i-1];
            end
        end
    end

    assign bus_rd_ack_o   = bus_v_q[RD_LATENCY-1];
    assign bus_rd_data_o  = bus_v_q[RD_LATENCY-1] ? bus_d_q[RD_LATENCY-1] : 32'd0;
    assign bus_wr_ack_o   = wr_ack_q;
    assign bus_irq_o      = irq_q;
    assign usr_rd_valid_o = usr_v_q[RD_LATENCY-1];
    assign usr_rd_data_o  = usr_d_q[RD_LATENCY-1];

endmodule

// File: tb/tb_bus_ram_dp.sv
// Randomised scoreboard bench for bus_ram_dp: byte-array reference model,
// expected reads queued with due cycle, negedge monitor compares DUT output.
module tb_bus_ram_dp;
    localparam int BA   = 'h1000;
    localparam int LS   = 10;
    localparam int LAT  = 3;
    localparam int UW   = 64;
    localparam int SIZE = 1 << LS;
    localparam int UB   = UW / 8;
    localparam int NB   = UW / 32;
    localparam int UAW  = LS - $clog2(UB);
    localparam int RA   = BA + SIZE;

    typedef struct { int due; logic [63:0] d; } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [31:0]    bus_addr = '0;
    logic           bus_rd = 1'b0, bus_wr = 1'b0;
    logic [3:0]     bus_be = '0;
    logic [31:0]    bus_wdata = '0;
    logic [31:0]    bus_rd_data_o;
    logic           bus_rd_ack_o, bus_wr_ack_o, bus_irq_o;
    logic [UAW-1:0] usr_addr = '0;
    logic           usr_rd = 1'b0, usr_we = 1'b0;
    logic [UB-1:0]  usr_be = '0;
    logic [UW-1:0]  usr_wdata = '0;
    logic [UW-1:0]  usr_rd_data_o;
    logic           usr_rd_valid_o;

    bus_ram_dp #(.BUS_ADDR(BA), .LOGSIZE(LS), .RD_LATENCY(LAT), .USR_WIDTH(UW)) dut (
        .bus_clk_i(clk), .bus_reset_l_i(rst_n),
        .bus_addr_i(bus_addr), .bus_rd_i(bus_rd), .bus_wr_i(bus_wr),
        .bus_be_i(bus_be), .bus_wr_data_i(bus_wdata),
        .bus_rd_data_o(bus_rd_data_o), .bus_rd_ack_o(bus_rd_ack_o),
        .bus_wr_ack_o(bus_wr_ack_o), .bus_irq_o(bus_irq_o),
        .usr_addr_i(usr_addr), .usr_rd_en_i(usr_rd), .usr_we_i(usr_we),
        .usr_be_i(usr_be), .usr_wr_data_i(usr_wdata),
        .usr_rd_data_o(usr_rd_data_o), .usr_rd_valid_o(usr_rd_valid_o)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0, failures = 0;
    logic [7:0]  mm [SIZE];
    logic [2:0]  m_ctrl = 3'b010;
    logic [15:0] m_coll = 16'd0;
    exp_t        bq [$];
    exp_t        uq [$];
    logic [63:0] last_u = '0;
    exp_t        me;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One bus + user transaction per cycle against the reference model.
    task automatic op(input logic brd, input logic bwr, input logic [31:0] ba,
                      input logic [3:0] be, input logic [31:0] bd,
                      input logic urd, input logic uwe, input logic [UAW-1:0] ua,
                      input logic [UB-1:0] ube, input logic [UW-1:0] ud);
        logic ram, rctl, rcol, bw_eff, uw_eff, same, coll, exp_ack, exp_irq;
        int off, w, ln, ub0;
        logic [3:0] ulbe;
        logic [63:0] v;
        exp_t e;
        ram  = (ba >= 32'(BA)) && (ba < 32'(BA + SIZE));
        rctl = (ba == 32'(RA));
        rcol = (ba == 32'(RA + 4));
        off  = ram ? int'(ba - 32'(BA)) : 0;
        w    = off / 4;
        ln   = w % NB;
        ulbe = ube[ln*4 +: 4];
        bw_eff = bwr && ram && !m_ctrl[0];
        uw_eff = uwe && m_ctrl[1];
        same   = ram && ((w / NB) == int'(ua));
        coll   = same && (brd || bwr) && ((uw_eff && ulbe != 4'h0) || (bw_eff && urd));
        ub0    = int'(ua) * UB;
        if (brd && (ram || rctl || rcol)) begin
            v = '0;
            if (ram) for (int k = 0; k < 4; k++) v[k*8 +: 8] = mm[off+k];
            else if (rctl) v = 64'(m_ctrl);
            else v = 64'(m_coll);
            e.due = cyc + LAT; e.d = v;
            bq.push_back(e);
        end
        if (urd) begin
            v = '0;
            for (int k = 0; k < UB; k++) v[k*8 +: 8] = mm[ub0+k];
            e.due = cyc + LAT; e.d = v;
            uq.push_back(e);
        end
        if (uw_eff) for (int k = 0; k < UB; k++) if (ube[k]) mm[ub0+k] = ud[k*8 +: 8];
        if (bw_eff) for (int k = 0; k < 4; k++) if (be[k]) mm[off+k] = bd[k*8 +: 8];
        if (bwr && rctl && be[0]) m_ctrl = bd[2:0];
        if (bwr && rcol) m_coll = coll ? 16'd1 : 16'd0;
        else if (coll && m_coll != 16'hFFFF) m_coll = m_coll + 16'd1;
        exp_ack = bwr && (ram || rctl || rcol);
        exp_irq = m_ctrl[2] && (m_coll != 16'd0);
        bus_rd = brd; bus_wr = bwr; bus_addr = ba; bus_be = be; bus_wdata = bd;
        usr_rd = urd; usr_we = uwe; usr_addr = ua; usr_be = ube; usr_wdata = ud;
        @(posedge clk);
        #1;
        chk("wr_ack", 64'(bus_wr_ack_o), 64'(exp_ack));
        chk("irq", 64'(bus_irq_o), 64'(exp_irq));
    endtask

    task automatic bwrite(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        op(1'b0, 1'b1, a, be, d, 1'b0, 1'b0, '0, '0, '0);
    endtask
    task automatic bread(input logic [31:0] a);
        op(1'b1, 1'b0, a, 4'h0, 32'h0, 1'b0, 1'b0, '0, '0, '0);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // Monitor: pops expectations as the DUT presents results; checks idle zeros and hold.
    always @(negedge clk) begin
        if (rst_n) begin
            while (bq.size() > 0 && bq[0].due < cyc) begin
                checks++; failures++;
                $display("FAIL bus_rd_ack_missing: got no ack required data %h at cycle %0d", bq[0].d, bq[0].due);
                void'(bq.pop_front());
            end
            if (bus_rd_ack_o) begin
                if (bq.size() > 0 && bq[0].due == cyc) begin
                    me = bq.pop_front();
                    chk("bus_rd_data", 64'(bus_rd_data_o), me.d);
                end else begin
                    checks++; failures++;
                    $display("FAIL bus_rd_ack_unexpected: got ack=1 required ack=0 at cycle %0d", cyc);
                end
            end else begin
                chk("bus_rd_data_idle", 64'(bus_rd_data_o), 64'd0);
            end
            while (uq.size() > 0 && uq[0].due < cyc) begin
                checks++; failures++;
                $display("FAIL usr_rd_valid_missing: got no valid required data %h at cycle %0d", uq[0].d, uq[0].due);
                void'(uq.pop_front());
            end
            if (usr_rd_valid_o) begin
                if (uq.size() > 0 && uq[0].due == cyc) begin
                    me = uq.pop_front();
                    last_u = me.d;
                    chk("usr_rd_data", 64'(usr_rd_data_o), me.d);
                end else begin
                    checks++; failures++;
                    $display("FAIL usr_rd_valid_unexpected: got valid=1 required valid=0 at cycle %0d", cyc);
                end
            end else begin
                chk("usr_rd_data_hold", 64'(usr_rd_data_o), last_u);
            end
        end
    end

    task automatic reset_model();
        bq.delete(); uq.delete();
        last_u = '0; m_ctrl = 3'b010; m_coll = 16'd0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_rd_ack", 64'(bus_rd_ack_o), 64'd0);
        chk("rst_rd_data", 64'(bus_rd_data_o), 64'd0);
        chk("rst_wr_ack", 64'(bus_wr_ack_o), 64'd0);
        chk("rst_irq", 64'(bus_irq_o), 64'd0);
        chk("rst_usr_valid", 64'(usr_rd_valid_o), 64'd0);
        chk("rst_usr_data", 64'(usr_rd_data_o), 64'd0);
    endtask

    initial begin
        logic brd, bwr, urd, uwe;
        logic [31:0] a, d;
        logic [3:0] be;
        logic [UAW-1:0] ua;
        logic [UB-1:0] ube;
        logic [UW-1:0] ud;
        int r, p;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < SIZE / 4; i++) bwrite(32'(BA + 4*i), 4'hF, $urandom);
        bread(32'(RA));
        bread(32'(RA + 4));

        bwrite(32'(BA), 4'hF, 32'h1111_1111);
        bwrite(32'(BA + 4), 4'hF, 32'h2222_2222);
        op(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, '0, '0, '0);
        bread(32'(BA)); bread(32'(BA + 4)); bread(32'(BA + 8));
        idle(LAT + 2);

        bwrite(32'(RA), 4'h1, 32'h0000_0001);
        bwrite(32'(BA + 8), 4'hF, 32'hDEAD_BEEF);
        bread(32'(BA + 8));
        op(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, UAW'(1), '1, 64'h0123_4567_89AB_CDEF);
        op(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, UAW'(1), '0, '0);
        bwrite(32'(RA), 4'h0, 32'h0000_0007);
        bread(32'(RA));
        bwrite(32'(RA), 4'h1, 32'h0000_0006);

        op(1'b0, 1'b1, 32'(BA), 4'h3, 32'hAAAA_AAAA, 1'b0, 1'b1, '0, UB'(8'h0F), 64'h5555_5555_5555_5555);
        bread(32'(BA));
        bread(32'(RA + 4));
        bwrite(32'(RA + 4), 4'h0, 32'h0);
        bwrite(32'(BA - 4), 4'hF, 32'h1234_5678);
        bread(32'(RA + 8));
        idle(LAT + 1);

        for (int i = 0; i < 'h10004; i++)
            op(1'b0, 1'b1, 32'(BA), 4'hF, 32'(i), 1'b1, 1'b0, '0, '0, '0);
        bread(32'(RA + 4));
        bwrite(32'(RA + 4), 4'hF, 32'hFFFF_FFFF);
        bread(32'(RA + 4));
        idle(LAT + 1);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            brd = (r < 40);
            bwr = (r >= 40 && r < 80);
            p = $urandom_range(0, 19);
            if (p < 14) a = 32'(BA) + 32'($urandom_range(0, 7)) * 32'd4;
            else if (p < 17) a = 32'(BA) + 32'($urandom_range(0, SIZE/4 - 1)) * 32'd4;
            else if (p == 17) a = 32'(RA);
            else if (p == 18) a = 32'(RA + 4);
            else a = ($urandom_range(0, 1) != 0) ? 32'(BA - 4) : 32'(RA + 8);
            be  = 4'($urandom);
            d   = $urandom;
            urd = ($urandom_range(0, 1) != 0);
            uwe = ($urandom_range(0, 2) == 0);
            ua  = UAW'($urandom_range(0, 3));
            ube = UB'($urandom);
            ud  = {$urandom, $urandom};
            op(brd, bwr, a, be, d, urd, uwe, ua, ube, ud);
        end
        idle(LAT + 1);

        op(1'b1, 1'b0, 32'(BA), '0, '0, 1'b1, 1'b0, '0, '0, '0);
        op(1'b1, 1'b0, 32'(BA + 4), '0, '0, 1'b1, 1'b0, UAW'(1), '0, '0);
        rst_n = 1'b0;
        reset_model();
        #2;
        check_reset_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(8);
        bread(32'(RA));
        bread(32'(RA + 4));
        idle(LAT + 3);

        chk("bus_queue_drained", 64'(bq.size()), 64'd0);
        chk("usr_queue_drained", 64'(uq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
